ef_apb_initiator: RTL and testbench

APB (v3, no PSLVERR/PPROT/PSTRB) bus initiator. It converts a simple valid/ready command/response interface into APB SETUP/ACCESS transfers. It lets self-checking benches and small on-chip sequencers drive the EF_UART_APB register file (and any other EF APB peripheral) from the master side. It handles one outstanding transfer at a time and has a PREADY-stall watchdog.

---
 rtl/ef_apb_initiator.sv | 119 +++++++++++
 tb/tb_ef_apb_initiator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ef_apb_initiator.sv
// APB (v3) initiator: turns a valid/ready command/response handshake into
// APB SETUP/ACCESS transfers, one at a time, with a PREADY-stall watchdog.
module ef_apb_initiator #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          busy,
   output logic [AW-1:0] PADDR,
   output logic          PWRITE,
   output logic          PSEL,
   output logic          PENABLE,
   output logic [DW-1:0] PWDATA,
   input  logic [DW-1:0] PRDATA,
   input  logic          PREADY
);

   localparam int CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic          accept, complete, abort;

   // NOTE: reset is synchronous, so it lives inside the clocked branch; state
   // uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            PSEL      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            // A late PREADY on the last allowed cycle beats the abort.
            if (PREADY) begin
               complete  = 1'b1;
               state_nxt = RESP;
            end else if (TIMEOUT != 0 && wait_cnt == LAST) begin
               abort     = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         wait_cnt  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
         end
         if (state == SETUP)
            wait_cnt <= '0;
         else if (state == ACCESS && !PREADY && TIMEOUT != 0)
            wait_cnt <= wait_cnt + 1'b1;
         if (complete) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= 1'b0;
         end else if (abort) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ef_apb_initiator.sv
// Directed bench for ef_apb_initiator against a small APB register-file slave
// with programmable wait states.
module tb_ef_apb_initiator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, psel, penable, pready;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ef_apb_initiator #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
      .PCLK(clk), .PRESETn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
      .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready)
   );

   // APB slave: 16-word register file, PREADY after wait_states low cycles.
   logic [31:0] mem [16];
   logic [7:0]  acc_cnt;
   logic [7:0]  wait_states;

   assign pready = psel && penable && (acc_cnt == wait_states);
   assign prdata = mem[paddr[5:2]];

   always @(posedge clk) begin
      if (!(psel && penable) || pready) acc_cnt <= '0;
      else                               acc_cnt <= acc_cnt + 8'd1;
      if (psel && penable && pready && pwrite) mem[paddr[5:2]] <= pwdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one command in IDLE; returns with the DUT in SETUP.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   // From SETUP, runs through ACCESS and returns the number of ACCESS cycles.
   task automatic run_access(output int n);
      tick();
      n = 0;
      while (penable && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n;
      int last;
      int nsetup;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0; wait_states = 8'd0;
      tick(); tick();

      check("rst_psel",    {31'd0, psel},      32'd0);
      check("rst_penable", {31'd0, penable},   32'd0);
      check("rst_rsp_vld", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err},   32'd0);
      check("rst_rdata",   rsp_rdata,          32'd0);
      check("rst_paddr",   paddr,              32'd0);
      check("rst_pwdata",  pwdata,             32'd0);
      check("rst_busy",    {31'd0, busy},      32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // Zero-wait write: SETUP, ACCESS, then RESP in cycle 3.
      issue(1'b1, 32'h0000_0004, 32'h0000_00A5);
      check("wr_setup_psel", {31'd0, psel},    32'd1);
      check("wr_setup_pen",  {31'd0, penable}, 32'd0);
      check("wr_setup_addr", paddr,            32'h4);
      check("wr_setup_data", pwdata,           32'hA5);
      check("wr_setup_rdy",  {31'd0, cmd_ready}, 32'd0);
      tick();
      check("wr_acc_psel", {31'd0, psel},    32'd1);
      check("wr_acc_pen",  {31'd0, penable}, 32'd1);
      check("wr_acc_addr", paddr,            32'h4);
      check("wr_acc_data", pwdata,           32'hA5);
      check("wr_acc_dir",  {31'd0, pwrite},  32'd1);
      tick();
      check("wr_rsp_vld",  {31'd0, rsp_valid}, 32'd1);
      check("wr_rsp_psel", {31'd0, psel},      32'd0);
      check("wr_rsp_err",  {31'd0, rsp_err},   32'd0);
      check("wr_rsp_data", rsp_rdata,          32'd0);
      take_rsp();
      check("wr_done_vld", {31'd0, rsp_valid}, 32'd0);

      // Read with 3 wait states after preloading the register.
      issue(1'b1, 32'h0000_0008, 32'h1234_5678);
      run_access(n);
      take_rsp();
      wait_states = 8'd3;
      issue(1'b0, 32'h0000_0008, 32'h0);
      run_access(n);
      check("rd3_access_cycles", n, 32'd4);
      check("rd3_rsp_vld", {31'd0, rsp_valid}, 32'd1);
      check("rd3_rdata",   rsp_rdata,          32'h1234_5678);
      check("rd3_err",     {31'd0, rsp_err},   32'd0);
      take_rsp();

      // Watchdog abort: PREADY never rises.
      wait_states = 8'd200;
      issue(1'b0, 32'h0000_0008, 32'h0);
      run_access(n);
      check("wd_access_cycles", n, 32'd16);
      check("wd_err",   {31'd0, rsp_err},   32'd1);
      check("wd_rdata", rsp_rdata,          32'd0);
      check("wd_psel",  {31'd0, psel},      32'd0);
      check("wd_vld",   {31'd0, rsp_valid}, 32'd1);
      take_rsp();

      // PREADY on the 16th ACCESS cycle wins over the abort.
      wait_states = 8'd15;
      issue(1'b0, 32'h0000_0008, 32'h0);
      run_access(n);
      check("wd16_access_cycles", n, 32'd16);
      check("wd16_err",   {31'd0, rsp_err}, 32'd0);
      check("wd16_rdata", rsp_rdata,        32'h1234_5678);
      take_rsp();

      // Response backpressure with a new command pending.
      wait_states = 8'd0;
      issue(1'b1, 32'h0000_000C, 32'hDEAD_BEEF);
      run_access(n);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_000C; cmd_wdata = '0;
      for (int i = 0; i < 5; i++) begin
         check("bp_vld",   {31'd0, rsp_valid}, 32'd1);
         check("bp_rdata", rsp_rdata,          32'd0);
         check("bp_err",   {31'd0, rsp_err},   32'd0);
         check("bp_cmd_rdy", {31'd0, cmd_ready}, 32'd0);
         check("bp_psel",  {31'd0, psel},      32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_idle_psel", {31'd0, psel},      32'd0);
      check("bp_idle_vld",  {31'd0, rsp_valid}, 32'd0);
      check("bp_idle_rdy",  {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      check("bp_setup_psel", {31'd0, psel},   32'd1);
      check("bp_setup_addr", paddr,           32'hC);
      check("bp_setup_dir",  {31'd0, pwrite}, 32'd0);
      run_access(n);
      check("bp_rdata_new", rsp_rdata, 32'hDEAD_BEEF);
      take_rsp();

      // Reset during an ACCESS wait state.
      wait_states = 8'd5;
      issue(1'b0, 32'h0000_0004, 32'h0);
      tick(); tick();
      check("mid_pen_before", {31'd0, penable}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_psel", {31'd0, psel},      32'd0);
      check("mrst_pen",  {31'd0, penable},   32'd0);
      check("mrst_busy", {31'd0, busy},      32'd0);
      check("mrst_vld",  {31'd0, rsp_valid}, 32'd0);
      tick();
      check("mrst_vld_after", {31'd0, rsp_valid}, 32'd0);
      wait_states = 8'd0;
      issue(1'b0, 32'h0000_0004, 32'h0);
      run_access(n);
      check("mrst_rd_vld",   {31'd0, rsp_valid}, 32'd1);
      check("mrst_rd_rdata", rsp_rdata,          32'hA5);
      take_rsp();

      // Back-to-back reads with rsp_ready tied high: one SETUP every 4 cycles.
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0008;
      last = -1;
      nsetup = 0;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (psel && !penable) begin
            if (last >= 0) check("b2b_spacing", i - last, 32'd4);
            last = i;
            nsetup++;
         end
      end
      check("b2b_setups", nsetup, 32'd4);
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("b2b_final_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
